// File: rtl/display_scan.sv
// Time-multiplexed hex scanner for a bin7seg decoder: one nibble and one
// active-low anode per slot, with frame-aligned value updates and leading-zero blanking.
module display_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);

  logic [PW-1:0]       pre;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] disp;

  logic                slotEnd;
  logic                frameEnd;
  logic [3:0]          curNibble;
  logic                litAbove;
  logic [DIGITS-1:0]   anNext;

  assign slotEnd  = (pre == PW'(PRESCALE - 1));
  assign frameEnd = slotEnd && (idx == IW'(DIGITS - 1));

  // A digit is a leading zero when it and every more significant digit are 0.
  always_comb begin
    curNibble = '0;
    litAbove  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(idx) == i) curNibble = disp[4*i +: 4];
      if ((i >= int'(idx)) && (disp[4*i +: 4] != 4'h0)) litAbove = 1'b1;
    end
    anNext = ~(DIGITS'(1) << idx);
    if (blank_lz && (idx != '0) && !litAbove) anNext = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      idx        <= '0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      nibble     <= 4'h0;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      pre <= slotEnd ? '0 : pre + PW'(1);
      if (slotEnd) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);

      frame_tick <= frameEnd;
      nibble     <= curNibble;
      an         <= anNext;

      // A load landing on the frame boundary bypasses the shadow so it shows next frame.
      if (load) begin
        shadow <= value;
        if (frameEnd) begin
          disp    <= value;
          pending <= 1'b0;
        end else begin
          pending <= 1'b1;
        end
      end else if (frameEnd && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Time-multiplexed 4-digit 7-segment scanner.
- Sits directly upstream of the bin7seg decoder (SOP or LUT variant). Drives one hex nibble per time slot into the decoder's A..D inputs and drives the matching digit anode.
- Accepts a full multi-digit value through a load strobe.
- Applies a new value only at a frame boundary, so the display never shows a mix of old and new digits.

Parameters:
- DIGITS, 4: number of multiplexed digits; legal range 2..8.
- PRESCALE, 50000: clock cycles each digit stays lit; minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- load  input  1  single-cycle strobe; captures value.
- value  input  4*DIGITS  hex value to show; nibble i drives digit i; digit 0 is the least significant.
- blank_lz  input  1  when 1, leading-zero digits are turned off.
- nibble  output  4  current digit's hex code; bit0 connects to decoder A, bit3 to decoder D.
- an  output  DIGITS  active-low one-hot anode enables.
- frame_tick  output  1  one-cycle pulse at the end of each full scan.
- pending  output  1  a loaded value is waiting for the next frame boundary.

Behaviour:

Registered state:
- pre: prescaler, width clog2(PRESCALE).
- idx: digit index, width clog2(DIGITS).
- shadow: holding register, 4*DIGITS bits.
- disp: displayed value, 4*DIGITS bits.
- pending flag.
- All outputs are registered.

Reset (async assert, sync release):
- pre=0, idx=0, shadow=0, disp=0, pending=0.
- nibble=0, an=all ones (all digits off), frame_tick=0.

Prescaler and digit index:
- pre counts 0..PRESCALE-1 and wraps to 0.
- slot_end = (pre==PRESCALE-1).
- On slot_end, idx advances by 1; after DIGITS-1 it wraps to 0.

Frame boundary:
- frame_end = slot_end && idx==DIGITS-1.
- frame_tick is asserted in the cycle after frame_end, for exactly 1 cycle.

Load and update rules (evaluated each cycle):
- load && !frame_end: shadow<=value, pending<=1. A repeated load overwrites shadow; last load wins.
- !load && frame_end && pending: disp<=shadow, pending<=0.
- load && frame_end: disp<=value directly, shadow<=value, pending<=0. The new value takes effect in the very next frame.
- frame_end && !pending && !load: disp is unchanged.

Output generation (one-cycle latency from idx/disp to pins):
- nibble <= disp[4*idx+3 : 4*idx].
- an <= ~(1<<idx), except when blanked.
- Blanking: when blank_lz=1, digit idx is blanked (an <= all ones) if idx>0 and every disp nibble at position >= idx is 0.
- Digit 0 is never blanked, so value 0 shows a single "0".
- nibble still presents the digit's value while blanked.

Other boundary conditions:
- rst_n asserted mid-frame or mid-slot: all state returns to reset values immediately, and any pending load is discarded.
- Changing blank_lz takes effect on the next registered output update. It does not wait for a frame boundary.
- The value port is sampled only when load=1.

Test Plan (DIGITS=4, PRESCALE=4):
1. Reset release with no load:
   - an=1111 during reset.
   - From the first cycle after release, an cycles 1110→1101→1011→0111, each for 4 cycles; nibble=0 throughout.
   - frame_tick pulses every 16 cycles.
2. load with value=16'hA3C5 mid-frame:
   - pending=1 until frame_end, then pending=0.
   - Next frame shows nibble 5,C,3,A on an=1110,1101,1011,0111.
   - The current frame still shows 0000.
3. Two loads before a boundary (16'h1111, then 16'h2222):
   - Only 2222 is displayed after the boundary; 1111 never appears.
4. load of 16'h00F7 asserted exactly in the frame_end cycle:
   - Next frame shows 7,F,0,0 with no extra frame of delay.
   - pending stays 0.
5. blank_lz=1 with disp=16'h0042:
   - Slots 2 and 3 give an=1111; slots 0 and 1 light with 2 and 4.
   - With disp=16'h0000, only digit 0 lights and shows 0.
   - With disp=16'h0402, digit 1 lights and shows 0 (not a leading zero); only digit 3 is blanked.
6. rst_n pulsed low mid-slot while pending=1:
   - Outputs drop immediately to reset values (an=1111, nibble=0, frame_tick=0).
   - After release the scan restarts at digit 0 showing 0000, and pending=0.
